// File: rtl/imem_arb_pkg.sv
// Shared constants and helpers for the instruction-memory arbiter.
// Port indices, the word-alignment mask and the legal-address test live here.
package imem_arb_pkg;

  localparam int PORT_IF    = 0;
  localparam int PORT_DBG   = 1;
  localparam int NUM_PORTS  = 2;

  // Addresses are widened to this width before the legality test.
  localparam int ADDR_MAX_W = 64;
  localparam int LIMIT_W    = ADDR_MAX_W + 1;

  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  typedef enum logic [0:0] {
    WIN_IF  = 1'b0,
    WIN_DBG = 1'b1
  } winner_e;

  // Legal means word aligned and strictly below the last byte of the memory;
  // the compare uses one extra bit so the limit itself cannot overflow.
  function automatic logic addr_legal(input logic [ADDR_MAX_W-1:0] addr,
                                      input int unsigned depth_words);
    logic [LIMIT_W-1:0] limit;
    logic               aligned;
    logic               in_range;
    limit    = LIMIT_W'(depth_words) << 2;
    aligned  = ((addr[1:0] & WORD_ALIGN_MASK) == 2'b00);
    in_range = ({1'b0, addr} < limit);
    return aligned && in_range;
  endfunction

endpackage

// File: rtl/imem_resp_reg.sv
// Per-port response register: one-cycle rvalid pulse with data and error flag.
// rdata/err hold their last value whenever the port is not loaded.
module imem_resp_reg
  import imem_arb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              legal,
  input  logic [DATA_W-1:0] mem_data,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              err
);

  logic              rvalid_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              err_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_reg <= 1'b0;
      rdata_reg  <= '0;
      err_reg    <= 1'b0;
    end else begin
      rvalid_reg <= load;
      if (load) begin
        // Illegal accesses never touch memory, so their data is forced to zero.
        rdata_reg <= legal ? mem_data : '0;
        err_reg   <= ~legal;
      end
    end
  end

  assign rvalid = rvalid_reg;
  assign rdata  = rdata_reg;
  assign err    = err_reg;

endmodule

// File: rtl/imem_arbiter.sv
// Two-port arbiter for a combinational-read instruction memory: IF has fixed
// priority, a starvation counter forces a DBG grant after STARVE_MAX refusals.
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int          ADDR_W      = 32,
  parameter int          DATA_W      = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned STARVE_MAX  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_err,
  output logic              mem_ce,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [NUM_PORTS-1:0]             req;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] addr;
  logic [NUM_PORTS-1:0]             legal;
  logic [NUM_PORTS-1:0]             gnt;
  logic [NUM_PORTS-1:0]             rvalid;
  logic [NUM_PORTS-1:0][DATA_W-1:0] rdata;
  logic [NUM_PORTS-1:0]             err;

  logic [CNT_W-1:0] starve_cnt_reg;
  logic [CNT_W-1:0] starve_cnt_next;
  logic             starve_hit;
  winner_e          winner;
  logic             any_gnt;

  assign req[PORT_IF]   = if_req;
  assign req[PORT_DBG]  = dbg_req;
  assign addr[PORT_IF]  = if_addr;
  assign addr[PORT_DBG] = dbg_addr;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign legal[gi] = addr_legal(ADDR_MAX_W'(addr[gi]), DEPTH_WORDS);

      imem_resp_reg #(
        .DATA_W (DATA_W)
      ) u_resp (
        .clk      (clk),
        .rst      (rst),
        .load     (gnt[gi]),
        .legal    (legal[gi]),
        .mem_data (mem_data),
        .rvalid   (rvalid[gi]),
        .rdata    (rdata[gi]),
        .err      (err[gi])
      );
    end
  endgenerate

  // Grants are suppressed while reset is held so nothing reaches memory.
  always_comb begin
    starve_hit    = (starve_cnt_reg == CNT_MAX);
    gnt           = '0;
    winner        = WIN_IF;
    if (!rst) begin
      if (req[PORT_DBG] && (!req[PORT_IF] || starve_hit)) begin
        gnt[PORT_DBG] = 1'b1;
        winner        = WIN_DBG;
      end else if (req[PORT_IF]) begin
        gnt[PORT_IF]  = 1'b1;
      end
    end
    any_gnt = |gnt;
  end

  always_comb begin
    mem_ce   = 1'b0;
    mem_addr = '0;
    if (any_gnt) begin
      if (winner == WIN_DBG) begin
        mem_ce   = legal[PORT_DBG];
        mem_addr = legal[PORT_DBG] ? addr[PORT_DBG] : '0;
      end else begin
        mem_ce   = legal[PORT_IF];
        mem_addr = legal[PORT_IF] ? addr[PORT_IF] : '0;
      end
    end
  end

  // Counts consecutive refused DBG cycles; any grant or dropped request clears it.
  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (!req[PORT_DBG] || gnt[PORT_DBG]) begin
      starve_cnt_next = '0;
    end else if (!starve_hit) begin
      starve_cnt_next = starve_cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_reg <= '0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
    end
  end

  assign if_gnt     = gnt[PORT_IF];
  assign if_rvalid  = rvalid[PORT_IF];
  assign if_rdata   = rdata[PORT_IF];
  assign if_err     = err[PORT_IF];
  assign dbg_gnt    = gnt[PORT_DBG];
  assign dbg_rvalid = rvalid[PORT_DBG];
  assign dbg_rdata  = rdata[PORT_DBG];
  assign dbg_err    = err[PORT_DBG];

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: one instance with STARVE_MAX = 8, one with 1.
// Memory word n reads back as 32'hC0DE_0000 | n; disabled memory returns DEADBEEF.
module tb_imem_arbiter;

  logic        clk = 1'b0;
  logic        rst;

  logic        if_req, dbg_req;
  logic [31:0] if_addr, dbg_addr;
  logic        if_gnt, if_rvalid, if_err, dbg_gnt, dbg_rvalid, dbg_err, mem_ce;
  logic [31:0] if_rdata, dbg_rdata, mem_addr, mem_data;

  logic        b_if_req, b_dbg_req;
  logic [31:0] b_if_addr, b_dbg_addr;
  logic        b_if_gnt, b_if_rvalid, b_if_err, b_dbg_gnt, b_dbg_rvalid, b_dbg_err, b_mem_ce;
  logic [31:0] b_if_rdata, b_dbg_rdata, b_mem_addr, b_mem_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign mem_data   = mem_ce   ? (32'hC0DE_0000 | {22'd0, mem_addr[11:2]})   : 32'hDEAD_BEEF;
  assign b_mem_data = b_mem_ce ? (32'hC0DE_0000 | {22'd0, b_mem_addr[11:2]}) : 32'hDEAD_BEEF;

  imem_arbiter #(.ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(1024), .STARVE_MAX(8)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
    .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
    .mem_ce(mem_ce), .mem_addr(mem_addr), .mem_data(mem_data)
  );

  imem_arbiter #(.ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(1024), .STARVE_MAX(1)) dut1 (
    .clk(clk), .rst(rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid),
    .if_rdata(b_if_rdata), .if_err(b_if_err),
    .dbg_req(b_dbg_req), .dbg_addr(b_dbg_addr), .dbg_gnt(b_dbg_gnt), .dbg_rvalid(b_dbg_rvalid),
    .dbg_rdata(b_dbg_rdata), .dbg_err(b_dbg_err),
    .mem_ce(b_mem_ce), .mem_addr(b_mem_addr), .mem_data(b_mem_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic dwin;
    rst = 1'b1;
    if_req = 1'b0; dbg_req = 1'b0; if_addr = '0; dbg_addr = '0;
    b_if_req = 1'b0; b_dbg_req = 1'b0; b_if_addr = 32'h0; b_dbg_addr = 32'h0;
    #3;
    chk("rst_if_gnt", {31'd0, if_gnt}, 32'd0);
    chk("rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_dbg_rvalid", {31'd0, dbg_rvalid}, 32'd0);
    chk("rst_mem_ce", {31'd0, mem_ce}, 32'd0);
    // request held during reset must not be granted
    if_req = 1'b1; if_addr = 32'h8;
    #1;
    chk("rst_gnt_masked", {31'd0, if_gnt}, 32'd0);
    tick(); tick();
    rst = 1'b0;
    #1;

    // 1. reset in the middle of a response
    chk("t1_if_gnt", {31'd0, if_gnt}, 32'd1);
    chk("t1_mem_ce", {31'd0, mem_ce}, 32'd1);
    chk("t1_mem_addr", mem_addr, 32'h8);
    tick();
    chk("t1_rvalid_pre", {31'd0, if_rvalid}, 32'd1);
    chk("t1_rdata_pre", if_rdata, 32'hC0DE_0002);
    if_req = 1'b0;
    rst = 1'b1;
    #1;
    chk("t1_rvalid_rst", {31'd0, if_rvalid}, 32'd0);
    chk("t1_rdata_rst", if_rdata, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("t1_no_pulse_a", {31'd0, if_rvalid}, 32'd0);
    tick();
    chk("t1_no_pulse_b", {31'd0, if_rvalid}, 32'd0);

    // 2. IF-only back-to-back stream
    if_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if_addr = 32'(i * 4);
      #1;
      chk("t2_if_gnt", {31'd0, if_gnt}, 32'd1);
      tick();
      chk("t2_if_rvalid", {31'd0, if_rvalid}, 32'd1);
      chk("t2_if_rdata", if_rdata, 32'hC0DE_0000 | 32'(i));
      chk("t2_if_err", {31'd0, if_err}, 32'd0);
      chk("t2_dbg_rvalid", {31'd0, dbg_rvalid}, 32'd0);
    end
    if_req = 1'b0;
    tick();
    chk("t2_if_rvalid_end", {31'd0, if_rvalid}, 32'd0);

    // 3. continuous contention, STARVE_MAX = 8 -> DBG on cycles 9 and 18
    if_req = 1'b1; if_addr = 32'h10;
    dbg_req = 1'b1; dbg_addr = 32'h20;
    for (int c = 1; c <= 18; c++) begin
      dwin = (c == 9) || (c == 18);
      #1;
      chk($sformatf("t3_if_gnt_c%0d", c), {31'd0, if_gnt}, {31'd0, ~dwin});
      chk($sformatf("t3_dbg_gnt_c%0d", c), {31'd0, dbg_gnt}, {31'd0, dwin});
      tick();
      chk($sformatf("t3_dbg_rvalid_c%0d", c), {31'd0, dbg_rvalid}, {31'd0, dwin});
      if (dwin) chk("t3_dbg_rdata", dbg_rdata, 32'hC0DE_0008);
      else      chk("t3_if_rdata", if_rdata, 32'hC0DE_0004);
      if (c == 10) chk("t3_dbg_rdata_hold", dbg_rdata, 32'hC0DE_0008);
    end
    if_req = 1'b0; dbg_req = 1'b0;
    tick();

    // 4. illegal DBG addresses, then the last legal word
    dbg_req = 1'b1;
    dbg_addr = 32'h6;
    #1;
    chk("t4_mis_gnt", {31'd0, dbg_gnt}, 32'd1);
    chk("t4_mis_ce", {31'd0, mem_ce}, 32'd0);
    tick();
    chk("t4_mis_rvalid", {31'd0, dbg_rvalid}, 32'd1);
    chk("t4_mis_err", {31'd0, dbg_err}, 32'd1);
    chk("t4_mis_rdata", dbg_rdata, 32'd0);
    dbg_addr = 32'h1000;
    #1;
    chk("t4_oor_gnt", {31'd0, dbg_gnt}, 32'd1);
    chk("t4_oor_ce", {31'd0, mem_ce}, 32'd0);
    tick();
    chk("t4_oor_err", {31'd0, dbg_err}, 32'd1);
    chk("t4_oor_rdata", dbg_rdata, 32'd0);
    dbg_addr = 32'h8000_0000;
    #1;
    chk("t4_hi_ce", {31'd0, mem_ce}, 32'd0);
    tick();
    chk("t4_hi_err", {31'd0, dbg_err}, 32'd1);
    dbg_addr = 32'hFFC;
    #1;
    chk("t4_last_ce", {31'd0, mem_ce}, 32'd1);
    tick();
    chk("t4_last_err", {31'd0, dbg_err}, 32'd0);
    chk("t4_last_rdata", dbg_rdata, 32'hC0DE_03FF);
    dbg_req = 1'b0;
    tick();

    // 5. DBG gives up after 3 refused cycles; counter must restart from 0
    if_req = 1'b1;
    dbg_addr = 32'h40;
    for (int c = 0; c < 5; c++) begin
      if_addr = 32'h100 + 32'(c * 4);
      dbg_req = (c < 3);
      #1;
      chk("t5_dbg_gnt", {31'd0, dbg_gnt}, 32'd0);
      tick();
      chk("t5_if_rdata", if_rdata, 32'hC0DE_0040 | 32'(c));
      chk("t5_dbg_rvalid", {31'd0, dbg_rvalid}, 32'd0);
    end
    if_addr = 32'h10;
    dbg_req = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      #1;
      chk($sformatf("t5_restart_dbg_gnt_c%0d", c), {31'd0, dbg_gnt}, {31'd0, (c == 9)});
      tick();
    end
    if_req = 1'b0; dbg_req = 1'b0;
    tick();

    // 6. STARVE_MAX = 1 -> strict alternation
    b_if_req = 1'b1; b_if_addr = 32'h0;
    b_dbg_req = 1'b1; b_dbg_addr = 32'h4;
    for (int c = 1; c <= 6; c++) begin
      #1;
      chk($sformatf("t6_if_gnt_c%0d", c), {31'd0, b_if_gnt}, {31'd0, (c % 2 == 1)});
      chk($sformatf("t6_dbg_gnt_c%0d", c), {31'd0, b_dbg_gnt}, {31'd0, (c % 2 == 0)});
      tick();
      chk("t6_if_rvalid", {31'd0, b_if_rvalid}, {31'd0, (c % 2 == 1)});
    end
    chk("t6_dbg_rdata", b_dbg_rdata, 32'hC0DE_0001);
    chk("t6_if_rdata", b_if_rdata, 32'hC0DE_0000);
    chk("t6_errs", {30'd0, b_if_err, b_dbg_err}, 32'd0);
    b_if_req = 1'b0; b_dbg_req = 1'b0;
    tick();
    chk("t6_dbg_rvalid_end", {31'd0, b_dbg_rvalid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
